step_ctrl: RTL

Run/step controller upstream of the pipeline. Generates the CPU pipeline clock from the 50 MHz board clock and replaces the ad-hoc switch between manual clock and 1 Hz clock.
- Modes: free-run, single-step, N-step burst, halt on PC breakpoint.
- Guarantees no runt pulses on the pipeline clock.
- Output `cpu_clock` drives counter, pipeline registers, register file and memories. `pc` is fed back from the counter.

---
 rtl/step_ctrl_pkg.sv | 18 +
 rtl/step_ctrl_edge_sync.sv | 28 ++
 rtl/step_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the run/step controller and its UI decoder.
package step_ctrl_pkg;

  // FSM encodings, also decoded by the UI.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FREE  = 3'd1,
    ST_STEP  = 3'd2,
    ST_BURST = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  localparam int unsigned RUN_HALF_DEF  = 25000000;
  localparam int unsigned STEP_HALF_DEF = 4;
  localparam int unsigned PC_W_DEF      = 16;
  localparam int unsigned CNT_W_DEF     = 16;

endpackage

// File: rtl/step_ctrl_edge_sync.sv
// Two-flop synchronizer followed by a one-clock rising-edge strobe.
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Synchronizer chain plus delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise_c = sync2 & ~sync3;

endmodule

// File: rtl/step_ctrl.sv
// Run/step controller generating the glitch-free pipeline clock.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned RUN_HALF  = RUN_HALF_DEF,
  parameter int unsigned STEP_HALF = STEP_HALF_DEF,
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_mode,
  input  logic             step_req,
  input  logic             burst_req,
  input  logic [7:0]       burst_len,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_clock,
  output logic             cpu_rise,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] step_count,
  output logic [2:0]       state
);

  localparam int unsigned HALF_MAX = (RUN_HALF > STEP_HALF) ? RUN_HALF : STEP_HALF;
  localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam logic [HALF_W-1:0] RUN_LAST  = HALF_W'(RUN_HALF - 1);
  localparam logic [HALF_W-1:0] STEP_LAST = HALF_W'(STEP_HALF - 1);

  state_t             state_q, state_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [7:0]         remain_q, remain_d;
  logic               cpu_clock_d, rise_d, busy_d, halted_d;
  logic [CNT_W-1:0]   count_d;
  logic               step_rise_c, burst_rise_c;
  logic [HALF_W-1:0]  half_last;
  logic               eoc, bp_hit, start;

  edge_sync u_step_sync (
    .clock  (clock),
    .reset  (reset),
    .din    (step_req),
    .rise_c (step_rise_c)
  );

  edge_sync u_burst_sync (
    .clock  (clock),
    .reset  (reset),
    .din    (burst_req),
    .rise_c (burst_rise_c)
  );

  // Half-period length depends on mode; end of cycle is the last low clock.
  assign half_last = (state_q == ST_FREE) ? RUN_LAST : STEP_LAST;
  assign eoc       = busy && !cpu_clock && (half_q == half_last);
  assign bp_hit    = bp_en && (pc == bp_addr);
  assign state     = state_q;

  // State and cycle-engine registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      half_q     <= '0;
      remain_q   <= '0;
      cpu_clock  <= 1'b0;
      cpu_rise   <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      step_count <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      remain_q   <= remain_d;
      cpu_clock  <= cpu_clock_d;
      cpu_rise   <= rise_d;
      busy       <= busy_d;
      halted     <= halted_d;
      step_count <= count_d;
    end
  end

  // Next-state logic: phase counting, mode transitions and cycle starts.
  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    remain_d    = remain_q;
    cpu_clock_d = cpu_clock;
    rise_d      = 1'b0;
    busy_d      = busy;
    halted_d    = halted;
    count_d     = step_count;
    start       = 1'b0;

    if (busy) begin
      if (half_q == half_last) begin
        half_d      = '0;
        cpu_clock_d = 1'b0;
      end else begin
        half_d = half_q + HALF_W'(1);
      end
    end
    if (eoc) begin
      busy_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!run_mode) begin
          state_d = ST_FREE;
        end else if (step_rise_c) begin
          state_d = ST_STEP;
        end else if (burst_rise_c && (burst_len != 8'd0)) begin
          state_d  = ST_BURST;
          remain_d = burst_len;
        end
      end
      ST_FREE: begin
        if (!busy) begin
          start = 1'b1;
        end else if (eoc) begin
          if (bp_hit) begin
            state_d  = ST_BRK;
            halted_d = 1'b1;
          end else if (run_mode) begin
            state_d = ST_IDLE;
          end else begin
            start = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (!busy) begin
          start = 1'b1;
        end else if (eoc) begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!busy) begin
          start = 1'b1;
        end else if (eoc) begin
          if (remain_q == 8'd1) begin
            state_d  = ST_IDLE;
            remain_d = '0;
          end else if (bp_hit) begin
            state_d  = ST_BRK;
            halted_d = 1'b1;
            remain_d = '0;
          end else begin
            remain_d = remain_q - 8'd1;
            start    = 1'b1;
          end
        end
      end
      ST_BRK: begin
        if (step_rise_c) begin
          state_d  = ST_STEP;
          halted_d = 1'b0;
        end else if (!bp_en) begin
          halted_d = 1'b0;
          state_d  = run_mode ? ST_IDLE : ST_FREE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start) begin
      cpu_clock_d = 1'b1;
      rise_d      = 1'b1;
      busy_d      = 1'b1;
      half_d      = '0;
      count_d     = step_count + CNT_W'(1);
    end
  end

endmodule
